arbitro_ula: RTL and testbench
==============================

Name: arbitro_ula

Overview:
- Sequencing controller and round-robin arbiter that shares one W-bit add/subtract unit between two requesters.
- Each request is either a single-width (W-bit) or a double-width (2W-bit) add or subtract.
- Double-width operations run as two passes through the shared unit (low half, then high half), chaining carry/borrow between passes.
- Sits between the control logic of the ULA and the arithmetic datapath; results and flags are registered.

Parameters:
- W, 8, width of the shared add/sub unit; double-width operands are 2W.
- Only requester count 2 is supported; it is fixed, not a parameter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  2  req[i] high = requester i wants an operation; held with stable operands until done[i]
op0  in  1  requester 0 operation: 0 = add (a+b), 1 = subtract (a-b)
dbl0  in  1  requester 0: 1 = 2W-bit operation, 0 = W-bit (upper operand halves ignored)
a0, b0  in  2W  requester 0 operands
op1, dbl1, a1, b1  in  1/1/2W/2W  same fields for requester 1
gnt  out  2  one-hot; gnt[i] high while requester i's operation is in progress
done  out  2  one-cycle pulse on completion for requester i
s  out  2W+1  result; s[2W] for double width, s[W] for single width = carry (add) or borrow (sub)
z  out  1  1 when the result bits (W or 2W wide, excluding carry/borrow) are all zero
ocupado  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; gnt=0, done=0, s=0, z=0, ocupado=0; priority pointer ptr=0.
- States: IDLE, BAIXO, ALTO, FIM.
- IDLE:
  - If any req is high, grant at the next edge.
  - If only one req is high, that requester wins.
  - If both are high, requester ptr wins.
  - At the granting edge: latch op, dbl, a, b of the winner; set gnt one-hot; go to BAIXO.
- BAIXO:
  - Shared unit computes low W bits with carry-in = 0 (add) or borrow-in = 0 (sub).
  - Register s[W-1:0] and the internal carry/borrow.
  - If dbl=0: s[W] = carry/borrow, upper bits = 0, go to FIM.
  - If dbl=1: go to ALTO.
- ALTO:
  - Unit computes high W bits with carry/borrow-in from BAIXO.
  - Register s[2W-1:W], s[2W] = carry/borrow out; go to FIM.
- FIM:
  - done[granted] = 1 for exactly this cycle; z valid.
  - ptr = the other requester; gnt=0; go to IDLE.
- Latency from the IDLE grant edge to the done pulse: 2 cycles for single width, 3 cycles for double width. One IDLE cycle is always inserted between operations.
- Subtraction semantics: s = a - b in two's complement of width W/2W; borrow = 1 iff a < b unsigned.
- s and z hold their value until the next operation's FIM; they are undefined-free (registered).
- A requester that drops req mid-operation does not abort it: the operation completes and done still pulses.
- A req still high in FIM is treated as a new request in the following IDLE, arbitrated normally with ptr already rotated.
- Operand changes after the grant edge are ignored, because operands are latched.
- Reset mid-operation: immediate return to reset values; no done pulse is emitted.

Decomposition:
- Shared package: state encoding (IDLE, BAIXO, ALTO, FIM), op codes OP_SOMA=0 and OP_SUB=1, default width constant.
- One sub-module, unidade_soma_sub: purely combinational W-bit add/sub with inputs a, b, op, cin and outputs s, cout.
  - cin/cout act as borrow when op = sub.
  - It is built from the existing full-adder/full-subtractor cells.
- arbitro_ula holds the FSM, arbiter, operand latches and result registers.

Test Plan:
1. Requester 0, single-width sub, a0=0x05, b0=0x03 -> done[0] 2 cycles after grant, s=0x00002, z=0; then a0=0x03, b0=0x05 -> s[7:0]=0xFE, s[8]=1.
2. Requester 1, dbl=1, add, a1=0x12FF, b1=0x0001 -> carry propagates BAIXO to ALTO, s=0x01300, done[1] 3 cycles after grant.
3. dbl=1, sub, 0x0100-0x0001 -> s=0x000FF, s[16]=0; then 0x0000-0x0001 -> s=0x1FFFF; then 0x1234-0x1234 -> s=0, z=1.
4. After reset, req=2'b11 held -> requester 0 served first, then requester 1; with both held continuously, grants alternate 0,1,0,1; exactly one done per operation.
5. rst_n pulsed low during ALTO -> outputs zero immediately, no done; after release with req[1] high, the next grant goes to requester 1 with ptr=0 logic verified.
6. req[0] dropped during BAIXO and operands changed -> result still uses the latched operands and done[0] still pulses.

Source files
------------

// File: rtl/arbitro_ula_pkg.sv
// rtl/arbitro_ula_pkg.sv - shared state encoding, op codes and default width for arbitro_ula
package arbitro_ula_pkg;

  localparam int W_PADRAO = 8;

  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_SUB  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BAIXO = 2'd1,
    ALTO  = 2'd2,
    FIM   = 2'd3
  } estado_t;

endpackage

// File: rtl/arbitro_ula_unidade_soma_sub.sv
// rtl/arbitro_ula_unidade_soma_sub.sv - combinational W-bit ripple add/sub, cin/cout are borrow on sub
module unidade_soma_sub
  import arbitro_ula_pkg::*;
#(
  parameter int W = W_PADRAO
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] a_ef;

  // Full adder and full subtractor share the sum; the borrow chain is the carry chain with a inverted.
  assign a_ef = a ^ {W{op == OP_SUB}};
  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_celula
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a_ef[i] & b[i]) | (c[i] & (a_ef[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/arbitro_ula.sv
// rtl/arbitro_ula.sv - round-robin arbiter and sequencer sharing one add/sub unit between two requesters
module arbitro_ula
  import arbitro_ula_pkg::*;
#(
  parameter int W = W_PADRAO
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req,
  input  logic           op0,
  input  logic           dbl0,
  input  logic [2*W-1:0] a0,
  input  logic [2*W-1:0] b0,
  input  logic           op1,
  input  logic           dbl1,
  input  logic [2*W-1:0] a1,
  input  logic [2*W-1:0] b1,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [2*W:0]   s,
  output logic           z,
  output logic           ocupado
);

  estado_t        estado, estado_prox;
  logic           ptr;
  logic           venc;
  logic           venc_prox;
  logic           op_r;
  logic           dbl_r;
  logic [2*W-1:0] a_r;
  logic [2*W-1:0] b_r;
  logic [W-1:0]   lo_r;
  logic           carry_r;

  logic [W-1:0]   u_a;
  logic [W-1:0]   u_b;
  logic           u_cin;
  logic [W-1:0]   u_s;
  logic           u_cout;

  // Sole requester wins; on contention the pointer decides.
  assign venc_prox = req[0] ? (req[1] & ptr) : 1'b1;

  assign u_a   = (estado == ALTO) ? a_r[2*W-1:W] : a_r[W-1:0];
  assign u_b   = (estado == ALTO) ? b_r[2*W-1:W] : b_r[W-1:0];
  assign u_cin = (estado == ALTO) ? carry_r : 1'b0;

  unidade_soma_sub #(.W(W)) u_soma_sub (
    .a    (u_a),
    .b    (u_b),
    .op   (op_r),
    .cin  (u_cin),
    .s    (u_s),
    .cout (u_cout)
  );

  always_comb begin
    estado_prox = estado;
    case (estado)
      IDLE:    if (|req) estado_prox = BAIXO;
      BAIXO:   estado_prox = dbl_r ? ALTO : FIM;
      ALTO:    estado_prox = FIM;
      FIM:     estado_prox = IDLE;
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_prox;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      venc    <= 1'b0;
      op_r    <= OP_SOMA;
      dbl_r   <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      lo_r    <= '0;
      carry_r <= 1'b0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      s       <= '0;
      z       <= 1'b0;
    end else begin
      done <= 2'b00;
      case (estado)
        IDLE: begin
          if (|req) begin
            venc  <= venc_prox;
            gnt   <= venc_prox ? 2'b10 : 2'b01;
            op_r  <= venc_prox ? op1  : op0;
            dbl_r <= venc_prox ? dbl1 : dbl0;
            a_r   <= venc_prox ? a1   : a0;
            b_r   <= venc_prox ? b1   : b0;
          end
        end
        BAIXO: begin
          lo_r    <= u_s;
          carry_r <= u_cout;
          if (!dbl_r) begin
            s    <= {{W{1'b0}}, u_cout, u_s};
            z    <= (u_s == '0);
            done <= gnt;
          end
        end
        ALTO: begin
          s    <= {u_cout, u_s, lo_r};
          z    <= ({u_s, lo_r} == '0);
          done <= gnt;
        end
        FIM: begin
          gnt <= 2'b00;
          ptr <= ~venc;
        end
        default: ;
      endcase
    end
  end

  assign ocupado = (estado != IDLE);

endmodule

// File: tb/tb_arbitro_ula.sv
// tb/tb_arbitro_ula.sv - scoreboard bench for arbitro_ula with directed hand-computed vectors
module tb_arbitro_ula;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic        op0, dbl0, op1, dbl1;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [16:0] s;
  logic        z;
  logic        ocupado;

  typedef struct {
    int          id;
    logic [16:0] s;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc[2];

  arbitro_ula #(.W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op0     (op0),
    .dbl0    (dbl0),
    .a0      (a0),
    .b0      (b0),
    .op1     (op1),
    .dbl1    (dbl1),
    .a1      (a1),
    .b1      (b1),
    .gnt     (gnt),
    .done    (done),
    .s       (s),
    .z       (z),
    .ocupado (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [16:0] es, input logic ez, input int lat);
    exp_t e;
    e.id = id; e.s = es; e.z = ez; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_op(input int id, input logic op, input logic dbl,
                        input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin op0 = op; dbl0 = dbl; a0 = a; b0 = b; end
    else         begin op1 = op; dbl1 = dbl; a1 = a; b1 = b; end
  endtask

  task automatic wait_done(input int id);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (done[id]) ok = 1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_done%0d: no done pulse within 20 cycles", id);
    end
  endtask

  task automatic wait_gnt(input int id);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (gnt[id]) ok = 1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_gnt%0d: no grant within 20 cycles", id);
    end
  endtask

  task automatic run_op(input int id, input logic op, input logic dbl,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] es, input logic ez, input int lat);
    @(negedge clk);
    push(id, es, ez, lat);
    set_op(id, op, dbl, a, b);
    req[id] = 1'b1;
    wait_done(id);
    req[id] = 1'b0;
  endtask

  // Monitor: pops one expectation per done pulse; latency is the number of cycles gnt was held.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc[0] = 0;
      cyc[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) cyc[i] = gnt[i] ? cyc[i] + 1 : 0;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=%b with empty scoreboard", done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_id", done, 32'(2'b01 << e.id));
          check("s", s, e.s);
          check("z", z, e.z);
          check("latency", cyc[e.id], e.lat);
        end
      end
    end
  end

  initial begin
    int ndone;
    rst_n = 1'b0;
    req   = 2'b00;
    set_op(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_op(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_z", z, 0);
    check("rst_ocupado", ocupado, 0);
    rst_n = 1'b1;

    // Single-width subtract, then borrow case; upper halves must be ignored.
    run_op(0, 1'b1, 1'b0, 16'h0005, 16'h0003, 17'h00002, 1'b0, 2);
    run_op(0, 1'b1, 1'b0, 16'h0003, 16'h0005, 17'h001FE, 1'b0, 2);
    run_op(0, 1'b0, 1'b0, 16'hAB_FF, 16'h5C_01, 17'h00100, 1'b1, 2);

    // Double-width: carry chained from low pass into high pass.
    run_op(1, 1'b0, 1'b1, 16'h12FF, 16'h0001, 17'h01300, 1'b0, 3);
    run_op(1, 1'b1, 1'b1, 16'h0100, 16'h0001, 17'h000FF, 1'b0, 3);
    run_op(1, 1'b1, 1'b1, 16'h0000, 16'h0001, 17'h1FFFF, 1'b0, 3);
    run_op(0, 1'b1, 1'b1, 16'h1234, 16'h1234, 17'h00000, 1'b1, 3);

    // Both requesting continuously after reset: 0,1,0,1.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_op(0, 1'b0, 1'b0, 16'h0010, 16'h0020);
    set_op(1, 1'b0, 1'b1, 16'h8000, 16'h8000);
    push(0, 17'h00030, 1'b0, 2);
    push(1, 17'h10000, 1'b1, 3);
    push(0, 17'h00030, 1'b0, 2);
    push(1, 17'h10000, 1'b1, 3);
    req = 2'b11;
    ndone = 0;
    for (int k = 0; k < 40 && ndone < 4; k++) begin
      @(negedge clk);
      if (done != 2'b00) ndone++;
    end
    req = 2'b00;
    check("rr_done_count", ndone, 4);

    // Reset during ALTO aborts without a done pulse.
    @(negedge clk);
    set_op(1, 1'b0, 1'b1, 16'h00FF, 16'h0001);
    req[1] = 1'b1;
    wait_gnt(1);
    @(negedge clk);
    check("alto_ocupado", ocupado, 1);
    rst_n = 1'b0;
    #1;
    check("abort_gnt", gnt, 0);
    check("abort_done", done, 0);
    check("abort_s", s, 0);
    check("abort_z", z, 0);
    check("abort_ocupado", ocupado, 0);
    @(negedge clk);
    set_op(1, 1'b1, 1'b1, 16'h0005, 16'h0007);
    push(1, 17'h1FFFE, 1'b0, 3);
    rst_n = 1'b1;
    wait_done(1);
    req[1] = 1'b0;

    // Requester drops req and scrambles operands after grant; latched values still used.
    @(negedge clk);
    push(0, 17'h00041, 1'b0, 2);
    set_op(0, 1'b0, 1'b0, 16'h0040, 16'h0001);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    set_op(0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(0);

    repeat (5) @(negedge clk);
    check("idle_after_drop", ocupado, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
